// File: rtl/issue_scheduler.sv
// issue_scheduler: instruction queue that issues the head when its ROB/RS/LSB resources have room.
// Optional blocked-issue counter enabled by defining ISSUE_STALL_CNT_EN.
module issue_scheduler #(
  parameter int QUEUE_DEPTH  = 8,
  parameter int QUEUE_ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_addr,
  output logic        queue_full,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  output logic        head_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  output logic        issue_out,
  output logic [31:0] stall_cycles
);
  localparam logic [QUEUE_ADDR_W:0] L_DEPTH = (QUEUE_ADDR_W+1)'(QUEUE_DEPTH);
  logic [31:0]             r_instr [QUEUE_DEPTH];
  logic [31:0]             r_addr  [QUEUE_DEPTH];
  logic [QUEUE_ADDR_W-1:0] r_head, r_tail;
  logic [QUEUE_ADDR_W:0]   r_count;
  logic                    w_is_mem, w_accept;
  assign head_valid     = r_count != '0;
  assign queue_full     = r_count == L_DEPTH;
  assign instr_out      = r_instr[r_head];
  assign instr_addr_out = r_addr[r_head];
  assign w_is_mem       = instr_out[6:0] == 7'b0000011 || instr_out[6:0] == 7'b0100011;
  assign issue_out      = rdy && !flush && head_valid && !rob_full && (w_is_mem ? !lsb_full : !rs_full);
  assign w_accept       = rdy && !flush && fetch_valid && r_count < L_DEPTH;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_accept) r_tail <= r_tail + 1'b1;
        if (issue_out) r_head <= r_head + 1'b1;
        r_count <= r_count + (QUEUE_ADDR_W+1)'(w_accept) - (QUEUE_ADDR_W+1)'(issue_out);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_instr[r_tail] <= fetch_instr;
      r_addr[r_tail]  <= fetch_addr;
    end
  end
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk) begin
    if (rst) r_stall <= '0;
    else if (rdy && !flush && head_valid && !issue_out && r_stall != '1) r_stall <= r_stall + 1'b1;
  end
  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed stimulus with a queue scoreboard checked every cycle.
module tb_issue_scheduler;
  logic clk = 0, rst, rdy, flush, fetch_valid, rob_full, rs_full, lsb_full;
  logic [31:0] fetch_instr, fetch_addr, instr_out, instr_addr_out, stall_cycles;
  logic queue_full, head_valid, issue_out;
  typedef struct {logic [31:0] i; logic [31:0] a;} ent_t;
  ent_t q[$];
  int n_pass = 0, n_total = 0, n_fail = 0;
  bit chk = 0;
  logic [31:0] e_stall = 0;
  issue_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .fetch_addr(fetch_addr), .queue_full(queue_full),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .head_valid(head_valid),
    .instr_out(instr_out), .instr_addr_out(instr_addr_out), .issue_out(issue_out),
    .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  function automatic logic is_mem(input logic [31:0] x);
    return x[6:0] == 7'b0000011 || x[6:0] == 7'b0100011;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // Reference model: compare outputs then advance to the post-edge state.
  always @(negedge clk) if (chk) begin
    logic e_iss, acc;
    e_iss = rdy && !flush && q.size() > 0 && !rob_full && (is_mem(q[0].i) ? !lsb_full : !rs_full);
    check("issue_out", issue_out, e_iss);
    check("head_valid", head_valid, q.size() != 0);
    check("queue_full", queue_full, q.size() == 8);
    check("stall_cycles", stall_cycles, e_stall);
    if (q.size() > 0) begin
      check("instr_out", instr_out, q[0].i);
      check("instr_addr_out", instr_addr_out, q[0].a);
    end
    if (rst) begin
      q.delete();
      e_stall = 0;
    end else if (rdy) begin
      acc = !flush && fetch_valid && q.size() < 8;
`ifdef ISSUE_STALL_CNT_EN
      if (!flush && q.size() > 0 && !e_iss && e_stall != 32'hFFFFFFFF) e_stall++;
`endif
      if (flush) q.delete();
      else begin
        if (e_iss) void'(q.pop_front());
        if (acc) q.push_back('{fetch_instr, fetch_addr});
      end
    end
  end
  task automatic fetch(input logic [31:0] i, input logic [31:0] a);
    fetch_valid = 1; fetch_instr = i; fetch_addr = a;
    cyc();
    fetch_valid = 0;
  endtask
  initial begin
    int n;
    rst = 1; rdy = 1; flush = 0; fetch_valid = 0; fetch_instr = 0; fetch_addr = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0;
    cyc(); cyc();
    rst = 0; chk = 1;
    check("reset_head_valid", head_valid, 0);
    check("reset_queue_full", queue_full, 0);
    fetch(32'h00500093, 32'h0);
    #3 check("first_issue", issue_out, 1);
    check("first_instr", instr_out, 32'h00500093);
    check("first_addr", instr_addr_out, 32'h0);
    cyc();
    #3 check("first_drained", head_valid, 0);
    lsb_full = 1;
    fetch(32'h0000A103, 32'h4);
    repeat (3) begin #3 check("load_blocked", issue_out, 0); cyc(); end
    lsb_full = 0;
    #3 check("load_released", issue_out, 1);
    cyc();
    lsb_full = 1;
    fetch(32'h002081B3, 32'h8);
    #3 check("add_ignores_lsb", issue_out, 1);
    cyc();
    lsb_full = 0; rob_full = 1;
    for (int i = 0; i < 8; i++) fetch(32'h00000013 | (i << 20), 32'(i * 4));
    #3 check("fill_full", queue_full, 1);
    fetch(32'h00000013 | (8 << 20), 32'h20);
    #3 check("reject_9th_full", queue_full, 1);
    check("reject_9th_head", instr_addr_out, 32'h0);
    rob_full = 0;
    n = 8;
    for (int c = 0; c < 40 && n < 20; c++) begin
      logic w;
      fetch_valid = 1; fetch_instr = (n % 3 == 0) ? 32'h0000A103 : 32'h00000013 | (n << 20);
      fetch_addr = 32'(n * 4);
      #3 w = !queue_full;
      cyc();
      if (w) n++;
    end
    fetch_valid = 0;
    check("refill_count", n, 20);
    repeat (12) cyc();
    check("wrap_drained", head_valid, 0);
    rob_full = 1;
    for (int i = 0; i < 3; i++) fetch(32'h00000033, 32'(32'h100 + i * 4));
    rob_full = 0; flush = 1; fetch_valid = 1; fetch_instr = 32'h00000013; fetch_addr = 32'h200;
    #3 check("flush_no_issue", issue_out, 0);
    cyc();
    flush = 0; fetch_valid = 0;
    #3 check("flush_empty", head_valid, 0);
    cyc();
    rob_full = 1;
    fetch(32'h00000033, 32'h300);
    fetch(32'h00002023, 32'h304);
    rob_full = 0; rdy = 0;
    for (int i = 0; i < 5; i++) begin
      flush = i[0]; fetch_valid = !i[0]; fetch_instr = 32'h13; fetch_addr = 32'h400;
      #3 check("freeze_no_issue", issue_out, 0);
      cyc();
    end
    rdy = 1; flush = 0; fetch_valid = 0;
    #3 check("thaw_first_addr", instr_addr_out, 32'h300);
    check("thaw_first_issue", issue_out, 1);
    cyc();
    #3 check("thaw_second_addr", instr_addr_out, 32'h304);
    cyc(); cyc();
    rst = 1; cyc(); rst = 0;
    rob_full = 1;
    fetch(32'h00000013, 32'h500);
    repeat (10) cyc();
`ifdef ISSUE_STALL_CNT_EN
    #3 check("stall_ten", stall_cycles, 10);
`else
    #3 check("stall_off", stall_cycles, 0);
`endif
    rob_full = 0;
    cyc(); cyc();
    check("final_empty", head_valid, 0);
    chk = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Instruction queue and issue sequencer between Fetcher and Decoder.
- Buffers fetched instructions with their PCs.
- Presents the head entry to the Decoder and fires the issue strobe only when the resources this instruction class needs have room:
  - ROB, plus LSB for load/store;
  - ROB, plus RS for all other classes.
- Flushes completely on a RoB misprediction clear.

Parameters:
- QUEUE_DEPTH, 8, number of buffered instructions; must be a power of two, at least 2.
- QUEUE_ADDR_W, 3, log2(QUEUE_DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global ready; when low, all state is frozen and issue_out=0.
- flush  input  1  RoB misprediction clear; empties the queue.
- fetch_valid  input  1  Fetcher offers an instruction this cycle.
- fetch_instr  input  32  instruction word.
- fetch_addr  input  32  instruction PC.
- queue_full  output  1  count==QUEUE_DEPTH; Fetcher must hold its instruction.
- rob_full  input  1  RoB cannot accept an entry.
- rs_full  input  1  RS cannot accept an entry.
- lsb_full  input  1  LSB cannot accept an entry.
- head_valid  output  1  queue non-empty.
- instr_out  output  32  head instruction word.
- instr_addr_out  output  32  head PC.
- issue_out  output  1  head is consumed this cycle; strobe to Decoder/RS/LSB/RoB.
- stall_cycles  output  32  blocked-issue counter (see Optional Feature).

Behaviour:
- Storage:
  - Circular buffer of {instr, addr}.
  - head_ptr, tail_ptr: QUEUE_ADDR_W bits, wrap naturally from QUEUE_DEPTH-1 to 0.
  - count: QUEUE_ADDR_W+1 bits, range 0..QUEUE_DEPTH.
- Reset (rst=1 at edge):
  - head_ptr=tail_ptr=count=0.
  - queue_full=0, head_valid=0, issue_out=0, stall_cycles=0.
  - instr_out and instr_addr_out show the entry-0 contents (don't-care while head_valid=0).
  - rst has priority over flush, fetch and issue, including mid-operation.
- Output path:
  - head_valid, instr_out, instr_addr_out are combinational from head_ptr/count.
  - No same-cycle bypass from fetch to output.
  - Minimum latency: fetch accepted at edge N, issue_out possible in cycle N+1.
- Class decode:
  - is_mem = (instr[6:0]==7'b0000011) or (instr[6:0]==7'b0100011).
  - Everything else is non-mem: R/I/B/LUI/AUIPC/JAL/JALR and unknown opcodes.
- Issue:
  - issue_out = rdy & !flush & head_valid & !rob_full & (is_mem ? !lsb_full : !rs_full).
  - is_mem ignores rs_full; non-mem ignores lsb_full.
  - On issue: head_ptr+=1.
- Enqueue:
  - accept = rdy & !flush & fetch_valid & (count<QUEUE_DEPTH).
  - Judged on pre-edge count: a full queue rejects even if an issue happens the same cycle.
  - On accept: write at tail_ptr, tail_ptr+=1.
  - A rejected instruction is not stored; the Fetcher re-presents it.
- Count:
  - count += accept - issue_out.
  - Simultaneous accept and issue leaves count unchanged; legal at any count from 1 to QUEUE_DEPTH-1.
- Flush (rst=0, flush=1):
  - Next cycle head_ptr=tail_ptr=count=0.
  - Same-cycle fetch is dropped; issue_out=0 that cycle.
- rdy=0:
  - No pointer, count or storage change.
  - issue_out=0.
  - flush is ignored while rdy=0.
- Boundaries:
  - Empty: issue_out=0.
  - Full: queue_full=1.
  - Pointer wrap is transparent: FIFO order is preserved across the wrap.

Optional Feature:
- Macro ISSUE_STALL_CNT_EN.
- Defined:
  - stall_cycles increments by 1 each cycle with rdy & !flush & head_valid & !issue_out.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined:
  - stall_cycles tied to 32'h0.
  - No counter logic is synthesized.

Test Plan:
- Reset then enqueue:
  - Stimulus: rst for 2 cycles; fetch 32'h00500093 at addr 32'h0 in cycle 3; all full flags low.
  - Response: issue_out=1 in cycle 4 with instr_out=32'h00500093 and instr_addr_out=0; head_valid=0 in cycle 5.
- Class gating:
  - Stimulus: head=load 32'h0000A103 with lsb_full=1, rs_full=0.
  - Response: issue_out=0 until lsb_full drops, then issue_out=1 in that same cycle.
  - Stimulus: head=add 32'h002081B3 with lsb_full=1, rs_full=0.
  - Response: issues immediately.
- Fill and wrap:
  - Stimulus: rob_full=1; enqueue 8 instructions at addrs 0x0..0x1C.
  - Response: queue_full=1 and a 9th fetch is rejected.
  - Stimulus: release rob_full and keep fetching.
  - Response: issue order follows addrs 0x0,0x4,...,0x1C then 0x20 and onward; correct across the pointer wrap.
- Flush with concurrent fetch:
  - Stimulus: 3 entries queued; flush=1 together with fetch_valid=1.
  - Response: issue_out=0 that cycle; next cycle head_valid=0 and count=0; the fetched instruction is absent.
- rdy freeze:
  - Stimulus: 2 entries queued, rdy=0 for 5 cycles with flush and fetch pulses.
  - Response: no issue; the same 2 entries issue in order after rdy=1.
- Stall counter (ISSUE_STALL_CNT_EN defined):
  - Stimulus: head valid, rob_full=1 for 10 cycles.
  - Response: stall_cycles=10.
  - Without the macro: stall_cycles remains 0.
